// File: rtl/aes_key_pkg.sv
// rtl/aes_key_pkg.sv - shared key ROM geometry and key arbiter state encoding
package aes_key_pkg;

  localparam int KEY_ADDR_BITS = 5;
  localparam int KEY_WIDTH     = 128;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_READ    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after last_grant
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  int               sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk last_grant+1 .. last_grant+N_REQ, so the previous winner is tried last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = 0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = int'(last_grant) + k;
      if (sum >= N_REQ) sum = sum - N_REQ;
      cand = IDX_W'(sum);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/key_rom_arbiter.sv
// rtl/key_rom_arbiter.sv - round-robin sharing of the registered key ROM between requesters
module key_rom_arbiter
  import aes_key_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_BITS  = KEY_ADDR_BITS,
  parameter int DATA_WIDTH = KEY_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*ADDR_BITS-1:0] req_idx,
  output logic [N_REQ-1:0]           req_ack,
  output logic [N_REQ-1:0]           key_valid,
  input  logic [N_REQ-1:0]           key_ready,
  output logic [DATA_WIDTH-1:0]      key_data,
  output logic                       rom_en,
  output logic [ADDR_BITS-1:0]       rom_addr,
  input  logic [DATA_WIDTH-1:0]      rom_data,
  output logic                       busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [1:0]           state;
  logic [IDX_W-1:0]     last_grant;
  logic [N_REQ-1:0]     grant_oh;
  logic [N_REQ-1:0]     arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic [ADDR_BITS-1:0] sel_idx;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req        (req),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) sel_idx = req_idx[i*ADDR_BITS +: ADDR_BITS];
    end
  end

  // rom_addr doubles as the latched index; it is only meaningful while rom_en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= IDX_W'(N_REQ - 1);
      grant_oh   <= '0;
      req_ack    <= '0;
      key_valid  <= '0;
      key_data   <= '0;
      rom_en     <= 1'b0;
      rom_addr   <= '0;
      busy       <= 1'b0;
    end else begin
      req_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            req_ack    <= arb_grant;
            grant_oh   <= arb_grant;
            last_grant <= arb_idx;
            rom_addr   <= sel_idx;
            rom_en     <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_READ;
          end
        end
        ST_READ: begin
          rom_en <= 1'b0;
          state  <= ST_CAPTURE;
        end
        // The ROM only drives its word in the cycle after en; it reads 0 otherwise.
        ST_CAPTURE: begin
          key_data  <= rom_data;
          key_valid <= grant_oh;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (|(key_ready & grant_oh)) begin
            key_valid <= '0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          key_valid <= '0;
          rom_en    <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_rom_arbiter.sv
// tb/tb_key_rom_arbiter.sv - self-checking bench for key_rom_arbiter with a registered ROM model
module tb_key_rom_arbiter;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req;
  logic [9:0]   req_idx;
  logic [1:0]   req_ack;
  logic [1:0]   key_valid;
  logic [1:0]   key_ready;
  logic [127:0] key_data;
  logic         rom_en;
  logic [4:0]   rom_addr;
  logic [127:0] rom_data;
  logic         busy;

  int errors = 0;
  int checks = 0;

  key_rom_arbiter #(.N_REQ(2), .ADDR_BITS(5), .DATA_WIDTH(128)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_idx   (req_idx),
    .req_ack   (req_ack),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_data  (key_data),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] key_of(input logic [4:0] idx);
    case (idx)
      5'd0:    return 128'hf69f2445df4f9b17ad2b417be66c3710;
      5'd2:    return 128'h2b7e151628aed2a6abf7158809cf4f3c;
      5'd4:    return 128'h603deb1015ca71be2b73aef0857d7781;
      5'd5:    return 128'h1f352c073b6108d72d9810a30914dff4;
      5'd6:    return 128'h7b0c785e27e8ad3f8223207104725dd4;
      5'd7:    return 128'h0;
      5'd31:   return 128'h6bc1bee22e409f96e93d7e117393172a;
      default: return {4{32'hc0de0000 | {27'd0, idx}}};
    endcase
  endfunction

  // ROM_key: registered read, output forced to 0 when en is low
  always_ff @(posedge clk) rom_data <= rom_en ? key_of(rom_addr) : 128'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; req_idx = '0; key_ready = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 2'b11; req_idx = '0; key_ready = '0;
    #3;
    checks++; if ({req_ack, key_valid, rom_en, rom_addr, busy} !== 12'd0)
      begin errors++; $display("FAIL reset_ctrl: got %b expected 0", {req_ack, key_valid, rom_en, rom_addr, busy}); end
    checks++; if (key_data !== 128'h0)
      begin errors++; $display("FAIL reset_key_data: got %h expected 0", key_data); end
    tick; tick;
    rst_n = 1'b1;
    tick;
    checks++; if (req_ack !== 2'b01)
      begin errors++; $display("FAIL reset_first_grant: got %b expected 01", req_ack); end
    req = '0;
    key_ready = 2'b11;
    repeat (5) tick;
  endtask

  task automatic test_single();
    int ack_at, valid_at, en_cnt;
    logic [1:0] ack_val, kv;
    logic [127:0] kd;
    logic [4:0] addr_seen;
    do_reset;
    ack_at = -1; valid_at = -1; en_cnt = 0; ack_val = '0; kv = '0; kd = '0; addr_seen = '0;
    req_idx = {5'd0, 5'd2}; req = 2'b01; key_ready = 2'b11;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (req_ack != 0 && ack_at < 0) begin ack_at = c; ack_val = req_ack; req = '0; end
      if (rom_en) begin en_cnt++; addr_seen = rom_addr; end
      if (key_valid != 0 && valid_at < 0) begin valid_at = c; kv = key_valid; kd = key_data; end
    end
    checks++; if (ack_at !== 0 || ack_val !== 2'b01)
      begin errors++; $display("FAIL single_ack: got cycle %0d value %b expected cycle 0 value 01", ack_at, ack_val); end
    checks++; if (en_cnt !== 1 || addr_seen !== 5'd2)
      begin errors++; $display("FAIL single_rom: got %0d enables addr %0d expected 1 enable addr 2", en_cnt, addr_seen); end
    checks++; if (valid_at - ack_at !== 2 || kv !== 2'b01)
      begin errors++; $display("FAIL single_latency: got %0d cycles valid %b expected 2 cycles valid 01", valid_at - ack_at, kv); end
    checks++; if (kd !== key_of(5'd2))
      begin errors++; $display("FAIL single_key: got %h expected %h", kd, key_of(5'd2)); end
    checks++; if (busy !== 1'b0 || key_valid !== 2'b00)
      begin errors++; $display("FAIL single_idle: got busy %b valid %b expected 0 00", busy, key_valid); end
  endtask

  task automatic test_contention();
    int nack, nkey;
    int ack_cyc [3];
    logic [1:0] ack_who [3];
    logic [1:0] kv_who [3];
    logic [127:0] keys [3];
    logic [1:0] ew;
    logic [127:0] ek;
    do_reset;
    nack = 0; nkey = 0;
    req_idx = {5'd5, 5'd4}; req = 2'b11; key_ready = 2'b11;
    for (int c = 0; c < 30 && nkey < 3; c++) begin
      tick;
      if (req_ack != 0 && nack < 3) begin ack_who[nack] = req_ack; ack_cyc[nack] = c; nack++; end
      if (key_valid != 0 && nkey < 3) begin kv_who[nkey] = key_valid; keys[nkey] = key_data; nkey++; end
    end
    req = '0;
    checks++; if (nack !== 3 || nkey !== 3)
      begin errors++; $display("FAIL contention_timeout: got %0d acks %0d keys expected 3 3", nack, nkey); end
    else begin
      for (int n = 0; n < 3; n++) begin
        ew = (n == 1) ? 2'b10 : 2'b01;
        ek = (n == 1) ? key_of(5'd5) : key_of(5'd4);
        checks++; if (ack_who[n] !== ew || kv_who[n] !== ew)
          begin errors++; $display("FAIL contention_order%0d: got ack %b valid %b expected %b", n, ack_who[n], kv_who[n], ew); end
        checks++; if (keys[n] !== ek)
          begin errors++; $display("FAIL contention_key%0d: got %h expected %h", n, keys[n], ek); end
      end
      checks++; if (ack_cyc[1] - ack_cyc[0] !== 4 || ack_cyc[2] - ack_cyc[1] !== 4)
        begin errors++; $display("FAIL contention_rate: got spacing %0d %0d expected 4 4", ack_cyc[1] - ack_cyc[0], ack_cyc[2] - ack_cyc[1]); end
    end
    repeat (5) tick;
  endtask

  task automatic test_backpressure();
    do_reset;
    req_idx = {5'd31, 5'd0}; req = 2'b10; key_ready = 2'b00;
    tick;
    checks++; if (req_ack !== 2'b10)
      begin errors++; $display("FAIL bp_ack1: got %b expected 10", req_ack); end
    req = 2'b01; key_ready = 2'b01;
    tick; tick;
    checks++; if (key_valid !== 2'b10 || key_data !== key_of(5'd31))
      begin errors++; $display("FAIL bp_first_valid: got %b %h expected 10 %h", key_valid, key_data, key_of(5'd31)); end
    for (int c = 0; c < 5; c++) begin
      tick;
      checks++; if (key_valid !== 2'b10 || key_data !== key_of(5'd31) || rom_en !== 1'b0 || req_ack !== 2'b00)
        begin errors++; $display("FAIL bp_stall%0d: got valid %b en %b ack %b data %h expected 10 0 00 %h", c, key_valid, rom_en, req_ack, key_data, key_of(5'd31)); end
    end
    key_ready = 2'b10;
    tick;
    checks++; if (key_valid !== 2'b00 || req_ack !== 2'b00)
      begin errors++; $display("FAIL bp_release: got valid %b ack %b expected 00 00", key_valid, req_ack); end
    key_ready = 2'b11;
    tick;
    checks++; if (req_ack !== 2'b01)
      begin errors++; $display("FAIL bp_pending_ack: got %b expected 01", req_ack); end
    req = '0;
    tick; tick;
    checks++; if (key_valid !== 2'b01 || key_data !== key_of(5'd0))
      begin errors++; $display("FAIL bp_pending_key: got %b %h expected 01 %h", key_valid, key_data, key_of(5'd0)); end
    repeat (3) tick;
  endtask

  task automatic test_wrap();
    logic [4:0] idx_list [3];
    logic [4:0] addr_seen;
    logic [127:0] kd;
    bit got_en, got_kv;
    idx_list[0] = 5'd0; idx_list[1] = 5'd31; idx_list[2] = 5'd7;
    do_reset;
    key_ready = 2'b11;
    for (int n = 0; n < 3; n++) begin
      req_idx = {5'd0, idx_list[n]}; req = 2'b01;
      got_en = 0; got_kv = 0; addr_seen = '0; kd = '1;
      for (int c = 0; c < 10 && !got_kv; c++) begin
        tick;
        if (req_ack != 0) req = '0;
        if (rom_en) begin got_en = 1; addr_seen = rom_addr; end
        if (key_valid == 2'b01) begin got_kv = 1; kd = key_data; end
      end
      tick;
      checks++; if (!got_en || addr_seen !== idx_list[n])
        begin errors++; $display("FAIL wrap_addr%0d: got en %b addr %0d expected 1 %0d", n, got_en, addr_seen, idx_list[n]); end
      checks++; if (!got_kv || kd !== key_of(idx_list[n]))
        begin errors++; $display("FAIL wrap_key%0d: got valid %b %h expected 1 %h", n, got_kv, kd, key_of(idx_list[n])); end
    end
  endtask

  task automatic test_reset_mid();
    bit stale, got;
    logic [127:0] kd;
    logic [1:0] kv;
    do_reset;
    req_idx = {5'd6, 5'd2}; req = 2'b01; key_ready = 2'b11;
    tick;
    req = '0;
    tick;
    checks++; if (busy !== 1'b1 || rom_en !== 1'b0)
      begin errors++; $display("FAIL mid_capture_state: got busy %b en %b expected 1 0", busy, rom_en); end
    rst_n = 1'b0;
    #1;
    checks++; if ({req_ack, key_valid, rom_en, rom_addr, busy} !== 12'd0 || key_data !== 128'h0)
      begin errors++; $display("FAIL mid_async_clear: got %b %h expected 0", {req_ack, key_valid, rom_en, rom_addr, busy}, key_data); end
    @(posedge clk); #1 rst_n = 1'b1;
    req = 2'b10;
    stale = 0; got = 0; kd = '0; kv = '0;
    for (int c = 0; c < 8 && !got; c++) begin
      tick;
      if (req_ack != 0) req = '0;
      if (key_valid[0]) stale = 1;
      if (key_valid != 0) begin got = 1; kv = key_valid; kd = key_data; end
    end
    tick;
    checks++; if (stale || kv !== 2'b10 || kd !== key_of(5'd6))
      begin errors++; $display("FAIL mid_after_reset: got stale %b valid %b %h expected 0 10 %h", stale, kv, kd, key_of(5'd6)); end
    req = 2'b11; key_ready = 2'b00;
    tick;
    checks++; if (req_ack !== 2'b01)
      begin errors++; $display("FAIL mid_next_grant: got %b expected 01", req_ack); end
    req = '0;
    tick; tick;
    rst_n = 1'b0;
    #1;
    checks++; if (key_valid !== 2'b00 || busy !== 1'b0)
      begin errors++; $display("FAIL mid_resp_reset: got valid %b busy %b expected 00 0", key_valid, busy); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_cancel();
    bit any_ack;
    do_reset;
    req_idx = {5'd3, 5'd9}; req = 2'b10; key_ready = 2'b11;
    tick;
    checks++; if (req_ack !== 2'b10)
      begin errors++; $display("FAIL cancel_ack1: got %b expected 10", req_ack); end
    req = 2'b01;
    tick; tick;
    checks++; if (key_valid !== 2'b10)
      begin errors++; $display("FAIL cancel_resp: got %b expected 10", key_valid); end
    req = 2'b00;
    any_ack = 0;
    for (int c = 0; c < 4; c++) begin
      tick;
      if (req_ack != 0) any_ack = 1;
    end
    checks++; if (any_ack || busy !== 1'b0 || key_valid !== 2'b00)
      begin errors++; $display("FAIL cancel_idle: got ack %b busy %b valid %b expected 0 0 00", any_ack, busy, key_valid); end
  endtask

  // Transaction-level model: a free arbiter grants round-robin on the next edge; a grant
  // enables the ROM for one cycle, offers the key two cycles later and retires on ready.
  task automatic test_random();
    logic       last_g, gsel, cand;
    bit         inflight, mvalid;
    int         age;
    logic [4:0] gidx;
    logic [1:0] exp_ack, exp_kv, prev_req, prev_ready, nreq;
    logic [4:0] prev_idx [2];
    logic [4:0] nidx [2];
    do_reset;
    last_g = 1'b1; gsel = 1'b0; inflight = 0; mvalid = 0; age = 0; gidx = '0;
    prev_req = '0; prev_ready = '0; prev_idx[0] = '0; prev_idx[1] = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick;
      exp_ack = '0;
      if (inflight) begin
        age++;
        if (mvalid && prev_ready[gsel]) inflight = 0;
      end else if (prev_req != 0) begin
        for (int k = 1; k <= 2; k++) begin
          cand = last_g + 1'(k);
          if (exp_ack == 0 && prev_req[cand]) begin exp_ack[cand] = 1'b1; gsel = cand; end
        end
        last_g = gsel; gidx = prev_idx[gsel]; inflight = 1; age = 0;
      end
      mvalid = inflight && age >= 2;
      exp_kv = '0;
      if (mvalid) exp_kv[gsel] = 1'b1;
      checks++; if (req_ack !== exp_ack)
        begin errors++; $display("FAIL rand_ack@%0d: got %b expected %b", cyc, req_ack, exp_ack); end
      checks++; if (key_valid !== exp_kv)
        begin errors++; $display("FAIL rand_valid@%0d: got %b expected %b", cyc, key_valid, exp_kv); end
      checks++; if (busy !== inflight || rom_en !== (inflight && age == 0))
        begin errors++; $display("FAIL rand_busy_en@%0d: got %b %b expected %b %b", cyc, busy, rom_en, inflight, inflight && age == 0); end
      if (inflight && age == 0) begin
        checks++; if (rom_addr !== gidx)
          begin errors++; $display("FAIL rand_addr@%0d: got %0d expected %0d", cyc, rom_addr, gidx); end
      end
      if (mvalid) begin
        checks++; if (key_data !== key_of(gidx))
          begin errors++; $display("FAIL rand_key@%0d: got %h expected %h", cyc, key_data, key_of(gidx)); end
      end
      nreq = req;
      nidx[0] = req_idx[4:0]; nidx[1] = req_idx[9:5];
      for (int i = 0; i < 2; i++) begin
        if (req[1'(i)] && exp_ack[1'(i)]) begin
          if ($urandom_range(0, 1) == 0) nreq[1'(i)] = 1'b0;
          else nidx[i] = 5'($urandom_range(0, 31));
        end else if (req[1'(i)]) begin
          if ($urandom_range(0, 9) == 0) nreq[1'(i)] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          nreq[1'(i)] = 1'b1;
          nidx[i] = 5'($urandom_range(0, 31));
        end
      end
      req = nreq;
      req_idx = {nidx[1], nidx[0]};
      key_ready = 2'($urandom_range(0, 3));
      prev_req = req; prev_ready = key_ready; prev_idx[0] = nidx[0]; prev_idx[1] = nidx[1];
    end
    req = '0; key_ready = 2'b11;
    repeat (6) tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_backpressure;
    test_wrap;
    test_reset_mid;
    test_cancel;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1ms");
    $fatal(1);
  end

endmodule
